axi_lite_demux_nslv: RTL and testbench

//  Parametrised 1-master -> NSLV-slave AXI-lite address demux between the core's LSU/IFU arbiter and its slaves (CLINT, SoC, ...).

---
 rtl/axi_lite_demux_nslv.sv | 191 +++++++++++++++++++
 tb/tb_axi_lite_demux_nslv.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_demux_nslv.sv
// 1-master to NSLV-slave AXI-lite demux with base/mask decode, one transaction in flight,
// alternating read/write priority and an internal DECERR responder for unmapped addresses.
module axi_lite_demux_nslv #(
  parameter int NSLV = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0200_0000, 32'h0},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFF_0000, 32'h0}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          m_araddr,
  input  logic                   m_arvalid,
  output logic                   m_arready,
  output logic [DW-1:0]          m_rdata,
  output logic [1:0]             m_rresp,
  output logic                   m_rvalid,
  input  logic                   m_rready,
  input  logic [AW-1:0]          m_awaddr,
  input  logic                   m_awvalid,
  output logic                   m_awready,
  input  logic [DW-1:0]          m_wdata,
  input  logic [DW/8-1:0]        m_wstrb,
  input  logic                   m_wvalid,
  output logic                   m_wready,
  output logic [1:0]             m_bresp,
  output logic                   m_bvalid,
  input  logic                   m_bready,
  output logic [NSLV*AW-1:0]     s_araddr,
  output logic [NSLV-1:0]        s_arvalid,
  input  logic [NSLV-1:0]        s_arready,
  input  logic [NSLV*DW-1:0]     s_rdata,
  input  logic [NSLV*2-1:0]      s_rresp,
  input  logic [NSLV-1:0]        s_rvalid,
  output logic [NSLV-1:0]        s_rready,
  output logic [NSLV*AW-1:0]     s_awaddr,
  output logic [NSLV-1:0]        s_awvalid,
  input  logic [NSLV-1:0]        s_awready,
  output logic [NSLV*DW-1:0]     s_wdata,
  output logic [NSLV*DW/8-1:0]   s_wstrb,
  output logic [NSLV-1:0]        s_wvalid,
  input  logic [NSLV-1:0]        s_wready,
  input  logic [NSLV*2-1:0]      s_bresp,
  input  logic [NSLV-1:0]        s_bvalid,
  output logic [NSLV-1:0]        s_bready
);

  // state   | meaning
  // IDLE    | no transaction; arbitrate and decode
  // RD_ADDR | AR forwarded to sel (or accepted internally on is_err)
  // RD_DATA | R returned from sel (or DECERR)
  // WR_ADDR | AW and W forwarded independently, tracked by aw_done/w_done
  // WR_RESP | B returned from sel (or DECERR)
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_ADDR = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  logic [2:0]    state;
  logic [SW-1:0] sel, dec_sel;
  logic          is_err, dec_hit, prio_wr, aw_done, w_done;
  logic          grant_rd, grant_wr;
  logic [AW-1:0] dec_addr;
  logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign s_araddr = {NSLV{m_araddr}};
  assign s_awaddr = {NSLV{m_awaddr}};
  assign s_wdata  = {NSLV{m_wdata}};
  assign s_wstrb  = {NSLV{m_wstrb}};

  assign grant_rd = m_arvalid & (~m_awvalid | ~prio_wr);
  assign grant_wr = m_awvalid & ~grant_rd;
  assign dec_addr = grant_rd ? m_araddr : m_awaddr;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((dec_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  always_comb begin
    s_arvalid = '0;
    s_rready  = '0;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    case (state)
      RD_ADDR: begin
        if (is_err) begin
          m_arready = 1'b1;
        end else begin
          s_arvalid[sel] = m_arvalid;
          m_arready      = s_arready[sel];
        end
      end
      RD_DATA: begin
        if (is_err) begin
          m_rvalid = 1'b1;
          m_rresp  = 2'b11;
        end else begin
          m_rvalid      = s_rvalid[sel];
          m_rdata       = s_rdata[sel*DW +: DW];
          m_rresp       = s_rresp[sel*2 +: 2];
          s_rready[sel] = m_rready;
        end
      end
      WR_ADDR: begin
        if (is_err) begin
          m_awready = ~aw_done;
          m_wready  = ~w_done;
        end else begin
          s_awvalid[sel] = m_awvalid & ~aw_done;
          s_wvalid[sel]  = m_wvalid & ~w_done;
          m_awready      = s_awready[sel] & ~aw_done;
          m_wready       = s_wready[sel] & ~w_done;
        end
      end
      WR_RESP: begin
        if (is_err) begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
        end else begin
          m_bvalid      = s_bvalid[sel];
          m_bresp       = s_bresp[sel*2 +: 2];
          s_bready[sel] = m_bready;
        end
      end
      default: ;
    endcase
  end

  assign ar_hs = m_arvalid & m_arready;
  assign r_hs  = m_rvalid & m_rready;
  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      is_err  <= 1'b0;
      prio_wr <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_rd | grant_wr) begin
            state  <= grant_rd ? RD_ADDR : WR_ADDR;
            sel    <= dec_sel;
            is_err <= ~dec_hit;
            if (m_arvalid & m_awvalid) prio_wr <= ~prio_wr;
          end
        end
        RD_ADDR: if (ar_hs) state <= RD_DATA;
        RD_DATA: if (r_hs) state <= IDLE;
        WR_ADDR: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
          end
        end
        WR_RESP: if (b_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_demux_nslv.sv
// Scoreboard bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_axi_lite_demux_nslv;

  logic clk, rst;
  int   chk_cnt = 0, pass_cnt = 0;

  // two-slave instance: slave0 = 0x0200_xxxx, slave1 = upper half
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_rresp, m_bresp;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready;
  logic [63:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [7:0]  s_wstrb;
  logic [3:0]  s_rresp, s_bresp;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic [1:0]  s_wvalid, s_wready, s_bvalid, s_bready;

  axi_lite_demux_nslv #(
    .NSLV(2), .AW(32), .DW(32),
    .SLV_BASE({32'h8000_0000, 32'h0200_0000}),
    .SLV_MASK({32'h8000_0000, 32'hFFFF_0000})
  ) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // three-slave instance with a catch-all slave2, read side only
  logic [31:0] m3_araddr, m3_rdata;
  logic [1:0]  m3_rresp, m3_bresp;
  logic m3_arvalid, m3_arready, m3_rvalid, m3_rready, m3_awready, m3_wready, m3_bvalid;
  logic [95:0] s3_araddr, s3_awaddr, s3_wdata;
  logic [11:0] s3_wstrb;
  logic [2:0]  s3_arvalid, s3_rready, s3_awvalid, s3_wvalid, s3_bready;
  logic [95:0] s3_rdata  = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
  logic [5:0]  s3_rresp  = '0;
  logic [5:0]  s3_bresp  = '0;
  logic [2:0]  s3_arready = '1;
  logic [2:0]  s3_rvalid  = '1;
  logic [2:0]  s3_awready = '0;
  logic [2:0]  s3_wready  = '0;
  logic [2:0]  s3_bvalid  = '0;
  logic [31:0] zero32 = '0;
  logic [3:0]  zero4  = '0;
  logic        zero1  = 1'b0;

  axi_lite_demux_nslv #(
    .NSLV(3), .AW(32), .DW(32),
    .SLV_BASE({32'h0, 32'h8000_0000, 32'h0200_0000}),
    .SLV_MASK({32'h0, 32'h8000_0000, 32'hFFFF_0000})
  ) dut3 (
    .clk(clk), .rst(rst),
    .m_araddr(m3_araddr), .m_arvalid(m3_arvalid), .m_arready(m3_arready),
    .m_rdata(m3_rdata), .m_rresp(m3_rresp), .m_rvalid(m3_rvalid), .m_rready(m3_rready),
    .m_awaddr(zero32), .m_awvalid(zero1), .m_awready(m3_awready),
    .m_wdata(zero32), .m_wstrb(zero4), .m_wvalid(zero1), .m_wready(m3_wready),
    .m_bresp(m3_bresp), .m_bvalid(m3_bvalid), .m_bready(zero1),
    .s_araddr(s3_araddr), .s_arvalid(s3_arvalid), .s_arready(s3_arready),
    .s_rdata(s3_rdata), .s_rresp(s3_rresp), .s_rvalid(s3_rvalid), .s_rready(s3_rready),
    .s_awaddr(s3_awaddr), .s_awvalid(s3_awvalid), .s_awready(s3_awready),
    .s_wdata(s3_wdata), .s_wstrb(s3_wstrb), .s_wvalid(s3_wvalid), .s_wready(s3_wready),
    .s_bresp(s3_bresp), .s_bvalid(s3_bvalid), .s_bready(s3_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave models for the two-slave instance
  logic [1:0]  ar_rdy, aw_rdy, w_rdy;
  int          rd_lat [2];
  logic [31:0] rd_data [2];
  logic [1:0]  rd_resp [2], b_resp [2];
  logic [1:0]  r_busy, aw_got, w_got;
  int          r_cnt [2];
  logic [31:0] w_seen [2];
  logic [3:0]  strb_seen [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      aw_got <= '0;
      w_got  <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_arvalid[i] && s_arready[i]) begin
          r_busy[i] <= 1'b1;
          r_cnt[i]  <= rd_lat[i];
        end else if (r_busy[i] && r_cnt[i] > 0) r_cnt[i] <= r_cnt[i] - 1;
        else if (s_rvalid[i] && s_rready[i]) r_busy[i] <= 1'b0;
        if (s_awvalid[i] && s_awready[i]) aw_got[i] <= 1'b1;
        if (s_wvalid[i] && s_wready[i]) begin
          w_got[i]     <= 1'b1;
          w_seen[i]    <= s_wdata[i*32 +: 32];
          strb_seen[i] <= s_wstrb[i*4 +: 4];
        end
        if (s_bvalid[i] && s_bready[i]) begin
          aw_got[i] <= 1'b0;
          w_got[i]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
    for (int i = 0; i < 2; i++) begin
      s_arready[i]         = ar_rdy[i];
      s_rvalid[i]          = r_busy[i] && (r_cnt[i] == 0);
      s_rdata[i*32 +: 32]  = rd_data[i];
      s_rresp[i*2 +: 2]    = rd_resp[i];
      s_awready[i]         = aw_rdy[i] & ~aw_got[i];
      s_wready[i]          = w_rdy[i] & ~w_got[i];
      s_bvalid[i]          = aw_got[i] & w_got[i];
      s_bresp[i*2 +: 2]    = b_resp[i];
    end
  end

  // scoreboard
  typedef struct { logic is_wr; logic [1:0] mask; } ord_t;
  ord_t        ord_q [$];
  logic [33:0] rd_q [$];
  logic [1:0]  wr_q [$];
  logic [31:0] rd3_q [$];
  ord_t        o;
  logic [33:0] re;
  logic [1:0]  act;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_arvalid && m_arready) begin
        if (ord_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          o = ord_q.pop_front();
          check("grant_is_wr", 0, {63'd0, o.is_wr});
          check("ar_route", {62'd0, s_arvalid}, {62'd0, o.mask});
        end
      end
      if (m_awvalid && m_awready) begin
        if (ord_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          o = ord_q.pop_front();
          check("grant_is_wr", 1, {63'd0, o.is_wr});
          check("aw_route", {62'd0, s_awvalid}, {62'd0, o.mask});
        end
      end
      if (m_rvalid && m_rready) begin
        if (rd_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          re = rd_q.pop_front();
          check("rdata_rresp", {30'd0, m_rdata, m_rresp}, {30'd0, re});
        end
      end
      if (m_bvalid && m_bready) begin
        if (wr_q.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", {62'd0, m_bresp}, {62'd0, wr_q.pop_front()});
      end
      if (m3_rvalid && m3_rready) begin
        if (rd3_q.size() == 0) check("r3_unexpected", 1, 0);
        else check("dec3_rdata", {32'd0, m3_rdata}, {32'd0, rd3_q.pop_front()});
      end
      act = '0;
      act = s_arvalid | s_rready | s_awvalid | s_wvalid | s_bready;
      if (act != 2'b00) check("single_slave_active", {63'd0, $onehot(act)}, 1);
    end
  end

  task automatic do_read(input logic [31:0] addr);
    int n; logic hs;
    m_araddr = addr; m_arvalid = 1'b1; m_rready = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 60) begin
      @(negedge clk); hs = m_arvalid && m_arready;
      @(posedge clk); #1; n++;
    end
    m_arvalid = 1'b0;
    if (!hs) check("ar_timeout", 1, 0);
    n = 0; hs = 1'b0;
    while (!hs && n < 60) begin
      @(negedge clk); hs = m_rvalid && m_rready;
      @(posedge clk); #1; n++;
    end
    m_rready = 1'b0;
    if (!hs) check("r_timeout", 1, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n; logic a, w, hs;
    m_awaddr = addr; m_awvalid = 1'b1; m_wdata = data; m_wstrb = strb; m_wvalid = 1'b1;
    m_bready = 1'b1;
    n = 0;
    while ((m_awvalid || m_wvalid) && n < 60) begin
      @(negedge clk); a = m_awvalid && m_awready; w = m_wvalid && m_wready;
      @(posedge clk); #1; n++;
      if (a) m_awvalid = 1'b0;
      if (w) m_wvalid = 1'b0;
    end
    if (m_awvalid || m_wvalid) check("aw_w_timeout", 1, 0);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    n = 0; hs = 1'b0;
    while (!hs && n < 60) begin
      @(negedge clk); hs = m_bvalid && m_bready;
      @(posedge clk); #1; n++;
    end
    m_bready = 1'b0;
    if (!hs) check("b_timeout", 1, 0);
  endtask

  task automatic do_read3(input logic [31:0] addr, input logic [2:0] mask, input logic [31:0] data);
    int n; logic hs;
    rd3_q.push_back(data);
    m3_araddr = addr; m3_arvalid = 1'b1; m3_rready = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 20) begin
      @(negedge clk); hs = m3_arvalid && m3_arready;
      if (hs) check("dec3_ar_route", {61'd0, s3_arvalid}, {61'd0, mask});
      @(posedge clk); #1; n++;
    end
    m3_arvalid = 1'b0;
    if (!hs) check("ar3_timeout", 1, 0);
    n = 0; hs = 1'b0;
    while (!hs && n < 20) begin
      @(negedge clk); hs = m3_rvalid && m3_rready;
      @(posedge clk); #1; n++;
    end
    m3_rready = 1'b0;
    if (!hs) check("r3_timeout", 1, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_ctrl"}, {59'd0, m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 0);
    check({tag, "_m_data"}, {28'd0, m_rdata, m_rresp, m_bresp}, 0);
    check({tag, "_s_ctrl"}, {54'd0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n; logic hs;
    rst = 1'b1;
    m_araddr = '0; m_arvalid = 0; m_rready = 0; m_awaddr = '0; m_awvalid = 0;
    m_wdata = '0; m_wstrb = '0; m_wvalid = 0; m_bready = 0;
    m3_araddr = '0; m3_arvalid = 0; m3_rready = 0;
    ar_rdy = '1; aw_rdy = '1; w_rdy = '1;
    for (int i = 0; i < 2; i++) begin
      rd_lat[i] = 1; rd_data[i] = '0; rd_resp[i] = 2'b00; b_resp[i] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // read to slave0, data 3 cycles after AR; slave valid one cycle after master valid
    rd_lat[0] = 3; rd_data[0] = 32'h1234;
    ord_q.push_back('{1'b0, 2'b01});
    rd_q.push_back({32'h1234, 2'b00});
    fork
      do_read(32'h0200_BFF8);
      begin
        @(negedge clk);
        check("idle_no_ar", {62'd0, s_arvalid}, 0);
        check("idle_no_ready", {63'd0, m_arready}, 0);
        @(negedge clk);
        check("ar_latency", {62'd0, s_arvalid}, 2'b01);
      end
    join

    // write to slave1, W handshakes two cycles before AW
    aw_rdy[1] = 1'b0; b_resp[1] = 2'b01;
    ord_q.push_back('{1'b1, 2'b10});
    wr_q.push_back(2'b01);
    fork
      do_write(32'h8000_0000, 32'hCAFE_F00D, 4'h5);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("w_drop_after_hs", {63'd0, s_wvalid[1]}, 0);
        check("aw_still_pending", {63'd0, s_awvalid[1]}, 1);
        check("bcast_awaddr", s_awaddr, {2{32'h8000_0000}});
        @(posedge clk); #1;
        aw_rdy[1] = 1'b1;
      end
    join
    check("slave1_wdata", {32'd0, w_seen[1]}, 32'hCAFE_F00D);
    check("slave1_wstrb", {60'd0, strb_seen[1]}, 4'h5);

    // contested requests: winners alternate R,W,R,W
    rd_lat[0] = 1; b_resp[1] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      rd_data[0] = 32'hA0 + k;
      if (k % 2 == 0) begin
        ord_q.push_back('{1'b0, 2'b01}); ord_q.push_back('{1'b1, 2'b10});
      end else begin
        ord_q.push_back('{1'b1, 2'b10}); ord_q.push_back('{1'b0, 2'b01});
      end
      rd_q.push_back({32'hA0 + k, 2'b00});
      wr_q.push_back(2'b00);
      fork
        do_read(32'h0200_0010);
        do_write(32'h8000_0010, 32'h1000 + k, 4'hF);
      join
    end

    // unmapped address answered with DECERR, no slave involved
    ord_q.push_back('{1'b0, 2'b00});
    rd_q.push_back({32'h0, 2'b11});
    do_read(32'h0300_0000);
    ord_q.push_back('{1'b1, 2'b00});
    wr_q.push_back(2'b11);
    do_write(32'h0300_0000, 32'hDEAD_BEEF, 4'hF);

    // reset while RD_DATA holds a response the master has not accepted
    rd_lat[0] = 1; rd_data[0] = 32'h55;
    ord_q.push_back('{1'b0, 2'b01});
    m_araddr = 32'h0200_0000; m_arvalid = 1'b1; m_rready = 1'b0;
    n = 0; hs = 1'b0;
    while (!hs && n < 20) begin
      @(negedge clk); hs = m_arvalid && m_arready;
      @(posedge clk); #1; n++;
    end
    m_arvalid = 1'b0;
    if (!hs) check("rst_ar_timeout", 1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_rvalid", {63'd0, m_rvalid}, 1);
    #1 rst = 1'b1;
    #1 check_outputs_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd_data[0] = 32'h77; rd_lat[0] = 0;
    ord_q.push_back('{1'b0, 2'b01});
    rd_q.push_back({32'h77, 2'b00});
    do_read(32'h0200_0004);

    // three slaves: lowest-index hit wins over the catch-all
    do_read3(32'h0200_0040, 3'b001, 32'hC0);
    do_read3(32'h9000_0000, 3'b010, 32'hC1);
    do_read3(32'h1234_0000, 3'b100, 32'hC2);
    do_read3(32'h0300_0000, 3'b100, 32'hC2);

    repeat (3) @(posedge clk);
    check("ord_q_drained", ord_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd3_q_drained", rd3_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
